// File: rtl/pwm_gen.sv
// Edge-stepped PWM generator: each rising edge of the divider output advances the
// period counter; period/duty settings are double-buffered and applied on a period boundary.
module pwm_gen #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_TOP = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_in,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_top,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] TOP_RST = WIDTH'(DEFAULT_TOP);

  logic             div_q_reg,        div_q_next;
  logic [WIDTH-1:0] cnt_reg,          cnt_next;
  logic [WIDTH-1:0] top_act_reg,      top_act_next;
  logic [WIDTH-1:0] duty_act_reg,     duty_act_next;
  logic             pend_reg,         pend_next;
  logic [WIDTH-1:0] pend_top_reg,     pend_top_next;
  logic [WIDTH-1:0] pend_duty_reg,    pend_duty_next;
  logic             pwm_reg,          pwm_next;
  logic             period_start_reg, period_start_next;

  logic step;
  logic boundary;
  logic accept;
  logic apply;

  always_comb begin
    step     = div_in & ~div_q_reg & enable;
    boundary = step & (cnt_reg == top_act_reg);
    accept   = cfg_valid & ~pend_reg;
    // While idle there is no boundary to wait for, so a pending setting lands at once.
    apply    = pend_reg & (boundary | ~enable);

    div_q_next        = div_in;
    cnt_next          = cnt_reg;
    top_act_next      = top_act_reg;
    duty_act_next     = duty_act_reg;
    pend_next         = pend_reg;
    pend_top_next     = pend_top_reg;
    pend_duty_next    = pend_duty_reg;
    pwm_next          = enable & (cnt_reg < duty_act_reg);
    period_start_next = boundary;

    if (!enable) begin
      cnt_next = '0;
    end else if (boundary) begin
      cnt_next = '0;
    end else if (step) begin
      cnt_next = cnt_reg + WIDTH'(1);
    end

    if (apply) begin
      top_act_next  = pend_top_reg;
      duty_act_next = pend_duty_reg;
      pend_next     = 1'b0;
    end

    // accept and apply are mutually exclusive: one needs pend low, the other pend high.
    if (accept) begin
      pend_top_next  = cfg_top;
      pend_duty_next = cfg_duty;
      pend_next      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q_reg        <= 1'b0;
      cnt_reg          <= '0;
      top_act_reg      <= TOP_RST;
      duty_act_reg     <= '0;
      pend_reg         <= 1'b0;
      pend_top_reg     <= '0;
      pend_duty_reg    <= '0;
      pwm_reg          <= 1'b0;
      period_start_reg <= 1'b0;
    end else begin
      div_q_reg        <= div_q_next;
      cnt_reg          <= cnt_next;
      top_act_reg      <= top_act_next;
      duty_act_reg     <= duty_act_next;
      pend_reg         <= pend_next;
      pend_top_reg     <= pend_top_next;
      pend_duty_reg    <= pend_duty_next;
      pwm_reg          <= pwm_next;
      period_start_reg <= period_start_next;
    end
  end

  assign cfg_ready    = ~pend_reg;
  assign pwm_out      = pwm_reg;
  assign period_start = period_start_reg;
  assign cnt          = cnt_reg;

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: a hand-computed vector table, scenario sequences
// for the multi-cycle corner cases, and randomized traffic against a queue-based model.
module tb_pwm_gen;

  logic       clk;
  logic       rst_n;
  logic       div_in;
  logic       enable;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_top;
  logic [7:0] cfg_duty;
  logic       pwm_out;
  logic       period_start;
  logic [7:0] cnt;

  pwm_gen #(.WIDTH(8), .DEFAULT_TOP(255)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .div_in       (div_in),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_top      (cfg_top),
    .cfg_duty     (cfg_duty),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .cnt          (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: active settings, a one-deep queue of pending settings,
  // and the values the outputs must show after the coming edge.
  typedef struct {
    logic [7:0] top;
    logic [7:0] duty;
  } cfg_t;
  cfg_t       pq[$];
  logic [7:0] m_cnt, m_top, m_duty;
  logic       m_divq, m_pwm, m_ps;
  bit         model_chk = 1'b0;

  bit div_run  = 1'b0;
  bit div_rand = 1'b0;
  int div_half = 2;
  int div_left = 2;

  typedef struct {
    logic       div;
    logic       en;
    logic       vld;
    logic [7:0] top;
    logic [7:0] duty;
    logic [7:0] e_cnt;
    logic       e_pwm;
    logic       e_ps;
    logic       e_rdy;
  } vec_t;
  vec_t tbl[18];

  function automatic vec_t mk(input logic d, input logic e, input logic v, input logic [7:0] t,
                              input logic [7:0] du, input logic [7:0] ec, input logic ep,
                              input logic eps, input logic er);
    vec_t r;
    r.div = d; r.en = e; r.vld = v; r.top = t; r.duty = du;
    r.e_cnt = ec; r.e_pwm = ep; r.e_ps = eps; r.e_rdy = er;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait expired t=%0t", nm, $time);
  endtask

  task automatic model_reset();
    m_cnt = 8'd0; m_top = 8'd255; m_duty = 8'd0;
    m_divq = 1'b0; m_pwm = 1'b0; m_ps = 1'b0;
    pq.delete();
  endtask

  // One clock: predict from the rules, advance, sample 1 time unit after the edge.
  task automatic cycle();
    bit         stp, bnd, acc;
    logic [7:0] ncnt;
    cfg_t       c;
    stp    = div_in && !m_divq && enable;
    bnd    = stp && (m_cnt == m_top);
    acc    = cfg_valid && (pq.size() == 0);
    m_pwm  = enable && (m_cnt < m_duty);
    m_ps   = bnd;
    if (!enable)  ncnt = 8'd0;
    else if (bnd) ncnt = 8'd0;
    else if (stp) ncnt = m_cnt + 8'd1;
    else          ncnt = m_cnt;
    if (pq.size() != 0 && (bnd || !enable)) begin
      c = pq.pop_front();
      m_top = c.top;
      m_duty = c.duty;
    end
    if (acc) begin
      c.top = cfg_top;
      c.duty = cfg_duty;
      pq.push_back(c);
    end
    m_cnt  = ncnt;
    m_divq = div_in;
    @(posedge clk);
    #1;
    if (model_chk) begin
      chk("cnt", cnt, m_cnt);
      chk("pwm_out", pwm_out, m_pwm);
      chk("period_start", period_start, m_ps);
      chk("cfg_ready", cfg_ready, pq.size() == 0);
    end
    if (div_run) begin
      if (div_left <= 1) begin
        div_in   = ~div_in;
        div_left = div_rand ? int'($urandom_range(1, 3)) : div_half;
      end else begin
        div_left--;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load_cfg_disabled(input logic [7:0] t, input logic [7:0] d);
    enable = 1'b0; cfg_valid = 1'b0;
    run(2);
    cfg_valid = 1'b1; cfg_top = t; cfg_duty = d;
    cycle();
    cfg_valid = 1'b0;
    run(2);
  endtask

  task automatic wait_cnt(input logic [7:0] v, input string nm);
    int n = 0;
    while (cnt !== v && n < 300) begin cycle(); n++; end
    if (cnt !== v) timeout(nm);
  endtask

  task automatic wait_ps(input string nm);
    int n = 0;
    while (period_start !== 1'b1 && n < 300) begin cycle(); n++; end
    if (period_start !== 1'b1) timeout(nm);
  endtask

  // Called on a period_start sample; runs to the next one.
  task automatic measure(output int maxc, output int highs, output int len);
    maxc = int'(cnt); highs = 0; len = 0;
    do begin
      cycle();
      cfg_valid = 1'b0;
      len++;
      highs += int'(pwm_out);
      if (period_start !== 1'b1 && int'(cnt) > maxc) maxc = int'(cnt);
    end while (period_start !== 1'b1 && len < 300);
  endtask

  task automatic check_period(input string nm, input int emax, input int ehigh, input int elen);
    int mx, hi, ln;
    measure(mx, hi, ln);
    chk({nm, "_maxcnt"}, mx, emax);
    chk({nm, "_pwm_high"}, hi, ehigh);
    chk({nm, "_len"}, ln, elen);
    $display("period %s: max_cnt=%0d pwm_high=%0d len=%0d", nm, mx, hi, ln);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, ps_n;
    bit ps_seen;
    int n;

    rst_n = 1'b0; div_in = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_top = 8'd0; cfg_duty = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    chk("rst_cnt", cnt, 8'd0);
    chk("rst_pwm", pwm_out, 1'b0);
    chk("rst_ps", period_start, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);

    // Hand-computed vectors: load top=3/duty=2 while idle, one full period, then top=0.
    tbl[0]  = mk(0, 0, 1, 3, 2, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 1);
    tbl[3]  = mk(1, 1, 0, 0, 0, 1, 1, 0, 1);
    tbl[4]  = mk(1, 1, 0, 0, 0, 1, 1, 0, 1);
    tbl[5]  = mk(0, 1, 0, 0, 0, 1, 1, 0, 1);
    tbl[6]  = mk(1, 1, 0, 0, 0, 2, 1, 0, 1);
    tbl[7]  = mk(1, 1, 0, 0, 0, 2, 0, 0, 1);
    tbl[8]  = mk(0, 1, 0, 0, 0, 2, 0, 0, 1);
    tbl[9]  = mk(1, 1, 0, 0, 0, 3, 0, 0, 1);
    tbl[10] = mk(0, 1, 0, 0, 0, 3, 0, 0, 1);
    tbl[11] = mk(1, 1, 0, 0, 0, 0, 0, 1, 1);
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 1, 0, 1);
    tbl[13] = mk(1, 1, 1, 0, 1, 1, 1, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 1, 0, 1);
    tbl[16] = mk(1, 1, 0, 0, 0, 0, 1, 1, 1);
    tbl[17] = mk(0, 1, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 18; i++) begin
      div_in = tbl[i].div; enable = tbl[i].en; cfg_valid = tbl[i].vld;
      cfg_top = tbl[i].top; cfg_duty = tbl[i].duty;
      cycle();
      chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].e_cnt);
      chk($sformatf("vec%0d_pwm", i), pwm_out, tbl[i].e_pwm);
      chk($sformatf("vec%0d_ps", i), period_start, tbl[i].e_ps);
      chk($sformatf("vec%0d_ready", i), cfg_ready, tbl[i].e_rdy);
      $display("vec %0d: div=%0b en=%0b vld=%0b -> cnt=%0d pwm=%0b ps=%0b rdy=%0b",
               i, div_in, enable, cfg_valid, cnt, pwm_out, period_start, cfg_ready);
    end
    cfg_valid = 1'b0;
    model_chk = 1'b1;

    // Basic PWM, top=3 duty=2, div period 4 clk.
    load_cfg_disabled(8'd3, 8'd2);
    enable = 1'b1; div_in = 1'b0; div_half = 2; div_left = 2; div_run = 1'b1;
    run(16);
    hi = 0; ps_n = 0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      hi += int'(pwm_out);
      ps_n += int'(period_start);
    end
    chk("basic_pwm_high", hi, 32);
    chk("basic_ps_count", ps_n, 4);
    $display("basic: pwm_high=%0d/64 period_starts=%0d", hi, ps_n);

    // Mid-period update at cnt=1, with a second offer held during the pending window.
    wait_cnt(8'd1, "mid_wait_cnt1");
    cfg_valid = 1'b1; cfg_top = 8'd7; cfg_duty = 8'd1;
    cycle();
    chk("mid_accept_ready_low", cfg_ready, 1'b0);
    cfg_top = 8'd5; cfg_duty = 8'd3;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 100) begin cycle(); n++; end
    if (cfg_ready !== 1'b1) timeout("mid_ready_rise");
    chk("mid_ready_with_wrap", period_start, 1'b1);
    chk("mid_ready_cnt0", cnt, 8'd0);
    $display("mid-update: ready rose after %0d cycles", n);
    check_period("mid_top7", 7, 4, 32);
    check_period("mid_top5", 5, 12, 24);

    // Enable drop at cnt=2, apply while idle, then re-enable.
    wait_cnt(8'd2, "drop_wait_cnt2");
    enable = 1'b0;
    cycle();
    chk("drop_cnt", cnt, 8'd0);
    chk("drop_pwm", pwm_out, 1'b0);
    cfg_valid = 1'b1; cfg_top = 8'd6; cfg_duty = 8'd4;
    cycle();
    cfg_valid = 1'b0;
    cycle();
    chk("drop_applied_ready", cfg_ready, 1'b1);
    enable = 1'b1;
    n = 0; ps_seen = 1'b0;
    while (cnt === 8'd0 && n < 50) begin cycle(); n++; ps_seen |= period_start; end
    chk("reen_first_cnt", cnt, 8'd1);
    chk("reen_no_ps", ps_seen, 1'b0);
    wait_ps("reen_wait_wrap");
    check_period("reen_top6", 6, 16, 28);
    $display("enable drop / re-enable sequence done");

    // Accept offered in the very cycle of a wrap.
    n = 0;
    while (!(div_in && !m_divq && enable && m_cnt == m_top) && n < 100) begin cycle(); n++; end
    cfg_valid = 1'b1; cfg_top = 8'd2; cfg_duty = 8'd1;
    cycle();
    cfg_valid = 1'b0;
    chk("simul_wrap", period_start, 1'b1);
    chk("simul_pending", cfg_ready, 1'b0);
    check_period("simul_old", 6, 16, 28);
    check_period("simul_new", 2, 4, 12);

    // Extremes.
    load_cfg_disabled(8'd5, 8'd9);
    enable = 1'b1;
    run(2);
    lo = 0;
    for (int i = 0; i < 48; i++) begin cycle(); lo += int'(!pwm_out); end
    chk("duty_gt_top_lows", lo, 0);
    load_cfg_disabled(8'd5, 8'd0);
    enable = 1'b1;
    hi = 0;
    for (int i = 0; i < 48; i++) begin cycle(); hi += int'(pwm_out); end
    chk("duty0_highs", hi, 0);
    load_cfg_disabled(8'd0, 8'd1);
    enable = 1'b1;
    run(8);
    ps_n = 0;
    for (int i = 0; i < 64; i++) begin cycle(); ps_n += int'(period_start); end
    chk("top0_ps_count", ps_n, 16);
    $display("extremes: lows=%0d highs=%0d top0_ps=%0d", lo, hi, ps_n);

    // Asynchronous reset mid-run with a pending config.
    load_cfg_disabled(8'd3, 8'd2);
    enable = 1'b1;
    run(9);
    cfg_valid = 1'b1; cfg_top = 8'd9; cfg_duty = 8'd4;
    cycle();
    cfg_valid = 1'b0;
    chk("prereset_pending", cfg_ready, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", cnt, 8'd0);
    chk("async_rst_pwm", pwm_out, 1'b0);
    chk("async_rst_ready", cfg_ready, 1'b1);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 1200; i++) begin cycle(); hi += int'(pwm_out); end
    chk("post_rst_pwm_high", hi, 0);
    $display("reset: 300 steps after release, pwm_high=%0d", hi);

    // Randomized traffic.
    div_rand = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      enable    = ($urandom_range(0, 19) != 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_top   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      cfg_duty  = 8'($urandom_range(0, (int'(cfg_top) + 2 > 255) ? 255 : int'(cfg_top) + 2));
      cycle();
    end
    cfg_valid = 1'b0;
    $display("random: 4000 cycles done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
